// File: rtl/signed_bcd_converter.sv
// Signed/unsigned value holder with button-driven load/negate and an iterative
// double-dabble binary-to-BCD conversion feeding the display outputs.
module signed_bcd_converter #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clkin,
    input  logic                  btnR,
    input  logic [W-1:0]          din,
    input  logic                  load,
    input  logic                  negate,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic                  ovf,
    output logic [W-1:0]          mag,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic            load_q, load_d;
    logic            negate_q, negate_d;
    logic [W-1:0]    val_q, val_d;
    logic [W-1:0]    sh_q, sh_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_i_q, neg_i_d;
    logic            ovf_i_q, ovf_i_d;
    logic [W-1:0]    mag_i_q, mag_i_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [BW-1:0]   bcd_q, bcd_d;

    logic            load_p, neg_p;
    logic [BW-1:0]   adj;
    logic [3:0]      nib;

    assign load_p = load & ~load_q;
    assign neg_p  = negate & ~negate_q;

    // Next-state, datapath and output computation
    always_comb begin
        state_d  = state_q;
        load_d   = load;
        negate_d = negate;
        val_d    = val_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_i_d  = neg_i_q;
        ovf_i_d  = ovf_i_q;
        mag_i_d  = mag_i_q;
        done_d   = 1'b0;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        adj      = acc_q;
        nib      = 4'd0;

        case (state_q)
            IDLE: begin
                // busy_q is still high during the done cycle; edges there are dropped
                if (!busy_q && (load_p || neg_p)) begin
                    if (load_p && neg_p) begin
                        val_d = W'(0) - din;
                    end else if (load_p) begin
                        val_d = din;
                    end else begin
                        val_d = W'(0) - val_q;
                    end
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_i_d = signed_mode & val_q[W-1];
                mag_i_d = neg_i_d ? (W'(0) - val_q) : val_q;
                ovf_i_d = signed_mode & (val_q == MIN_NEG);
                sh_d    = mag_i_d;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    nib = acc_q[4*i +: 4];
                    if (nib >= 4'd5) begin
                        nib = nib + 4'd3;
                    end
                    adj[4*i +: 4] = nib;
                end
                {acc_d, sh_d} = {adj[BW-2:0], sh_q, 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                neg_d   = neg_i_q;
                ovf_d   = ovf_i_q;
                mag_d   = mag_i_q;
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // State and output registers
    always_ff @(posedge clkin) begin
        if (btnR) begin
            state_q  <= IDLE;
            load_q   <= 1'b1;
            negate_q <= 1'b1;
            val_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_i_q  <= 1'b0;
            ovf_i_q  <= 1'b0;
            mag_i_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            mag_q    <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            negate_q <= negate_d;
            val_q    <= val_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_i_q  <= neg_i_d;
            ovf_i_q  <= ovf_i_d;
            mag_i_q  <= mag_i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign mag  = mag_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed plus randomized bench for signed_bcd_converter (W=8, DIGITS=3)
// against an arithmetic reference model of the held value and its display.
module tb_signed_bcd_converter;

    localparam int unsigned W      = 8;
    localparam int unsigned DIGITS = 3;
    localparam int          LAT    = W + 2;

    logic                clkin = 1'b0;
    logic                btnR;
    logic [W-1:0]        din;
    logic                load;
    logic                negate;
    logic                signed_mode;
    logic                busy;
    logic                done;
    logic                neg;
    logic                ovf;
    logic [W-1:0]        mag;
    logic [4*DIGITS-1:0] bcd;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]        mval;
    logic                e_neg, e_ovf;
    logic [W-1:0]        e_mag;
    logic [4*DIGITS-1:0] e_bcd;

    signed_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
        .clkin(clkin), .btnR(btnR), .din(din), .load(load), .negate(negate),
        .signed_mode(signed_mode), .busy(busy), .done(done), .neg(neg),
        .ovf(ovf), .mag(mag), .bcd(bcd)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Display model: sign/magnitude by arithmetic, BCD by repeated division
    task automatic model(input logic [W-1:0] v, input logic sm);
        int m;
        int t;
        e_neg = sm && (int'(v) >= (1 << (W - 1)));
        m     = e_neg ? ((1 << W) - int'(v)) : int'(v);
        e_ovf = sm && (int'(v) == (1 << (W - 1)));
        e_mag = W'(m);
        t     = m;
        for (int k = 0; k < int'(DIGITS); k++) begin
            e_bcd[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_neg"}, 32'(neg), 32'(e_neg));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, "_mag"}, 32'(mag), 32'(e_mag));
        chk({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
    endtask

    task automatic expect_quiet(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clkin); #1;
            if (done) seen++;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    // One button operation; poke raises a second negate edge while busy
    task automatic run_op(input logic l, input logic n, input logic [W-1:0] d,
                          input logic sm, input bit poke, input string tag);
        int lat = -1;
        if (l && n)  mval = W'(0) - d;
        else if (l)  mval = d;
        else         mval = W'(0) - mval;
        model(mval, sm);
        @(negedge clkin);
        din = d; signed_mode = sm; load = l; negate = n;
        @(posedge clkin); #1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clkin); #1;
            if (i == 1) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (poke && i == 1) negate = 1'b0;
            if (poke && i == 3) negate = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        chk_out(tag);
        load = 1'b0; negate = 1'b0;
        @(posedge clkin); #1;
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        btnR = 1'b1; load = 1'b1; negate = 1'b0; din = '0; signed_mode = 1'b0;
        mval = '0;
        model(mval, 1'b0);

        // Reset with load held; no capture after release
        repeat (2) @(posedge clkin);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_out("rst");
        @(negedge clkin);
        btnR = 1'b0;
        expect_quiet(15, "rst_hold");
        chk_out("rst_after");
        chk("rst_after_busy", 32'(busy), 32'd0);
        load = 1'b0;
        @(posedge clkin);

        run_op(1'b1, 1'b0, 8'h17, 1'b1, 1'b0, "basic");
        chk("basic_bcd_const", 32'(bcd), 32'h023);
        run_op(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "basic_neg");

        run_op(1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, "a0_signed");
        chk("a0_signed_bcd_const", 32'(bcd), 32'h096);
        run_op(1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, "a0_unsigned");
        chk("a0_unsigned_bcd_const", 32'(bcd), 32'h160);
        run_op(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, "ff_unsigned");
        chk("ff_unsigned_bcd_const", 32'(bcd), 32'h255);

        run_op(1'b1, 1'b0, 8'h80, 1'b1, 1'b0, "minneg");
        chk("minneg_ovf_const", 32'(ovf), 32'd1);
        run_op(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "minneg_negate");
        chk("minneg_negate_bcd_const", 32'(bcd), 32'h128);

        // A mode change alone must not re-convert
        @(negedge clkin);
        signed_mode = 1'b0;
        expect_quiet(6, "mode_hold");
        chk_out("mode_hold");

        run_op(1'b1, 1'b1, 8'h05, 1'b1, 1'b1, "simul");
        chk("simul_bcd_const", 32'(bcd), 32'h005);
        expect_quiet(15, "simul_poke");

        run_op(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "zero");
        run_op(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "zero_neg");

        for (int r = 0; r < 24; r++) begin
            int op;
            op = int'($urandom_range(0, 2));
            run_op(op != 1, op != 0, W'($urandom), 1'($urandom), 1'b0, "rand");
        end

        // Reset during CONV discards the conversion
        @(negedge clkin);
        din = 8'h17; signed_mode = 1'b1; load = 1'b1;
        @(posedge clkin);
        repeat (5) @(posedge clkin);
        #1;
        btnR = 1'b1;
        @(posedge clkin); #1;
        btnR = 1'b0;
        mval = '0;
        model(mval, 1'b1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk_out("midrst");
        load = 1'b0;
        expect_quiet(15, "midrst");
        run_op(1'b1, 1'b0, 8'h17, 1'b1, 1'b0, "post_rst");
        chk("post_rst_bcd_const", 32'(bcd), 32'h023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_bcd_converter.md
Name: signed_bcd_converter

Overview:
- Parametrised successor to the lab sign-changer datapath.
- Captures a W-bit value from the switches on a load button edge, and negates the held value (two's-complement wrap) on each negate button edge.
- Converts the value to sign + magnitude, then to BCD with an iterative double-dabble FSM.
- Outputs feed the 7-segment mux and LEDs; signed/unsigned mode is selectable; the most-negative value is flagged.

Parameters:
- W, 8, data width in bits (supported range 4..16).
- DIGITS, 3, number of BCD digits. Must satisfy 10^DIGITS > 2^W - 1; otherwise elaboration is unsupported.

Ports:
- clkin, input, 1, system clock; all state updates on its rising edge.
- btnR, input, 1, synchronous active-high reset.
- din, input, W, value to capture (switches).
- load, input, 1, raw level button; its rising edge captures din.
- negate, input, 1, raw level button; its rising edge negates the held value.
- signed_mode, input, 1, 1 = interpret value as two's complement, 0 = unsigned.
- busy, output, 1, conversion in progress.
- done, output, 1, one-cycle pulse when outputs update.
- neg, output, 1, displayed value is negative.
- ovf, output, 1, held value is -2^(W-1) in signed mode (negation has no effect).
- mag, output, W, unsigned magnitude.
- bcd, output, 4*DIGITS, magnitude in BCD, digit 0 in bits [3:0].

Behaviour:
- Clock and reset: one clock, clkin. Reset btnR is synchronous, active-high, and overrides everything.
- Reset values:
  - Outputs: busy=0, done=0, neg=0, ovf=0, mag=0, bcd=0.
  - Internal: held value val=0, state=IDLE.
  - Edge registers load_q and negate_q are set to 1, so a button held through reset does not trigger.
- Edge detection: load_p = load & ~load_q, neg_p = negate & ~negate_q.
  - load_q and negate_q sample every cycle in every state.
  - A level held high produces exactly one pulse.
- States: IDLE, PREP, CONV, DONE.
- IDLE:
  - load_p & ~neg_p: val <= din, go PREP.
  - neg_p & ~load_p: val <= -val (mod 2^W), go PREP.
  - load_p & neg_p in the same cycle: val <= -din (mod 2^W), go PREP.
- PREP (1 cycle):
  - If signed_mode & val[W-1]: neg_i=1, mag_i = -val as unsigned W bits. For val = 2^(W-1), mag_i = 2^(W-1).
  - Otherwise: neg_i=0, mag_i=val.
  - ovf_i = signed_mode & (val == 1 followed by W-1 zeros).
  - Load the shift register with mag_i and clear the BCD accumulator. Go CONV with cnt=0.
- CONV (exactly W cycles):
  - Each cycle, every accumulator nibble >= 5 gets +3, then the combined {accumulator, shift register} shifts left 1.
  - cnt increments each cycle; after cnt==W-1, go DONE.
- DONE (1 cycle):
  - Register neg/ovf/mag/bcd from the internal values.
  - done=1 for this single cycle. Go IDLE.
- busy: high in PREP, CONV and DONE, low in IDLE. busy falls on the same edge that done falls.
- Latency: with the pulse sampled at edge 0, outputs and done change at edge W+2. For W=8 that is 10 clocks.
- While busy:
  - load_p and neg_p are ignored, not queued.
  - din and signed_mode changes have no effect until the next capture.
  - signed_mode is sampled only in PREP.
- Hold: outputs hold their last converted values in IDLE. A signed_mode change alone does not re-convert.
- Wrap: repeated negation of 2^(W-1) leaves val unchanged and ovf=1. Negating 0 gives 0, neg=0.
- Reset mid-operation: on the next edge everything returns to reset values and the in-flight conversion is discarded. No done is generated.

Test Plan:
1. Reset: btnR=1 for 2 cycles with load held high, then btnR=0 and load kept high -> all outputs 0, busy=0, no done ever fires.
2. Basic load: signed_mode=1, din=0x17, load rises -> done 10 cycles later; neg=0, mag=0x17, bcd=0x023, ovf=0. Then a negate edge -> neg=1, mag=0x17, bcd=0x023.
3. Signed vs unsigned:
   - din=0xA0, signed_mode=1, load -> neg=1, mag=0x60, bcd=0x096.
   - Repeat with signed_mode=0 -> neg=0, mag=0xA0, bcd=0x160.
   - din=0xFF, signed_mode=0 -> bcd=0x255.
4. Overflow: din=0x80, signed_mode=1, load -> neg=1, mag=0x80, bcd=0x128, ovf=1. Negate -> identical outputs, ovf=1.
5. Simultaneous edges: din=0x05, load and negate rise in the same cycle -> neg=1, bcd=0x005. A negate edge while busy -> ignored, exactly one done observed.
6. Reset mid-conversion: btnR=1 for 1 cycle during CONV (cycle 5 after load) -> next cycle all outputs 0, busy=0, no done. A subsequent load with din=0x17 converts normally to bcd=0x023.
